// File: rtl/branch_resolver_if.sv
// branch_resolver_if: bundle between the pipeline (ID/EX/hazard side) and the
// execute-stage branch resolver.
//   master : pipeline side; drives stall, the ID branch fields and the EX
//            operands, observes resolution results.
//   slave  : branch_resolver side.
// Signals:
//   stall_i              load-use stall (ID held, EX gets a bubble)
//   id_branch_i          ID holds a conditional branch
//   id_prediction_i      predictor output for that branch (1 = taken)
//   id_funct3_i          branch funct3
//   id_pc_i/id_target_i  branch PC and taken target
//   ex_rs1/rs2_data_i    forwarded operands for the instruction in EX
//   branch_taken_o       actual outcome to the predictor
//   branch_taken_valid_o one-cycle predictor update strobe
//   flush_o              misprediction squash
//   redirect_valid_o     same as flush_o
//   redirect_pc_o        correct next PC, 0 when no redirect
//   branch_count_o       resolved branches (saturating)
//   mispredict_count_o   mispredicted branches (saturating)
interface branch_resolver_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             stall_i;
  logic             id_branch_i;
  logic             id_prediction_i;
  logic [2:0]       id_funct3_i;
  logic [PC_W-1:0]  id_pc_i;
  logic [PC_W-1:0]  id_target_i;
  logic [31:0]      ex_rs1_data_i;
  logic [31:0]      ex_rs2_data_i;
  logic             branch_taken_o;
  logic             branch_taken_valid_o;
  logic             flush_o;
  logic             redirect_valid_o;
  logic [PC_W-1:0]  redirect_pc_o;
  logic [CNT_W-1:0] branch_count_o;
  logic [CNT_W-1:0] mispredict_count_o;

  modport master (
    output stall_i, id_branch_i, id_prediction_i, id_funct3_i, id_pc_i,
           id_target_i, ex_rs1_data_i, ex_rs2_data_i,
    input  branch_taken_o, branch_taken_valid_o, flush_o, redirect_valid_o,
           redirect_pc_o, branch_count_o, mispredict_count_o
  );

  modport slave (
    input  stall_i, id_branch_i, id_prediction_i, id_funct3_i, id_pc_i,
           id_target_i, ex_rs1_data_i, ex_rs2_data_i,
    output branch_taken_o, branch_taken_valid_o, flush_o, redirect_valid_o,
           redirect_pc_o, branch_count_o, mispredict_count_o
  );
endinterface

// File: rtl/branch_resolver.sv
// branch_resolver: execute-stage branch resolution. Captures the ID branch
// into an EX slot, evaluates the real condition from forwarded operands,
// drives the predictor update pair, raises flush/redirect on a
// misprediction and keeps saturating branch/mispredict counters.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    branch_resolver_if.slave (see interface header for signals)
// PC_W / CNT_W must match the parameters of the connected interface.
module branch_resolver #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  branch_resolver_if.slave   bus
);

  logic             ex_valid;
  logic             ex_pred;
  logic [2:0]       ex_funct3;
  logic [PC_W-1:0]  ex_pc;
  logic [PC_W-1:0]  ex_target;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  logic             actual;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;

  always_comb begin
    actual = 1'b0;
    unique case (ex_funct3)
      3'b000:  actual = (bus.ex_rs1_data_i == bus.ex_rs2_data_i);
      3'b001:  actual = (bus.ex_rs1_data_i != bus.ex_rs2_data_i);
      3'b100:  actual = ($signed(bus.ex_rs1_data_i) <  $signed(bus.ex_rs2_data_i));
      3'b101:  actual = ($signed(bus.ex_rs1_data_i) >= $signed(bus.ex_rs2_data_i));
      3'b110:  actual = (bus.ex_rs1_data_i <  bus.ex_rs2_data_i);
      3'b111:  actual = (bus.ex_rs1_data_i >= bus.ex_rs2_data_i);
      // 010/011 are not real branch encodings; they resolve as not taken
      default: actual = 1'b0;
    endcase
  end

  always_comb begin
    mispredict  = ex_valid & (actual != ex_pred);
    redirect_pc = '0;
    if (mispredict) begin
      // fall-through wraps modulo 2^PC_W
      redirect_pc = actual ? ex_target : ex_pc + PC_W'(4);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid         <= 1'b0;
      ex_pred          <= 1'b0;
      ex_funct3        <= '0;
      ex_pc            <= '0;
      ex_target        <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      // the branch sitting in ID during a flush is wrong-path; a stall
      // inserts a bubble and ID re-presents the branch later
      if (mispredict || bus.stall_i) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid  <= bus.id_branch_i;
        ex_pred   <= bus.id_prediction_i;
        ex_funct3 <= bus.id_funct3_i;
        ex_pc     <= bus.id_pc_i;
        ex_target <= bus.id_target_i;
      end

      if (ex_valid && (branch_count != '1)) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if (mispredict && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

  assign bus.branch_taken_valid_o = ex_valid;
  assign bus.branch_taken_o       = ex_valid & actual;
  assign bus.flush_o              = mispredict;
  assign bus.redirect_valid_o     = mispredict;
  assign bus.redirect_pc_o        = redirect_pc;
  assign bus.branch_count_o       = branch_count;
  assign bus.mispredict_count_o   = mispredict_count;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolver_if #(.PC_W(32), .CNT_W(32)) bus_m ();
  branch_resolver_if #(.PC_W(32), .CNT_W(2))  bus_s ();

  branch_resolver #(.PC_W(32), .CNT_W(32)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_m.slave)
  );

  branch_resolver #(.PC_W(32), .CNT_W(2)) u_dut_sat (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_s.slave)
  );

  // the narrow-counter instance sees exactly the same stimulus
  assign bus_s.stall_i         = bus_m.stall_i;
  assign bus_s.id_branch_i     = bus_m.id_branch_i;
  assign bus_s.id_prediction_i = bus_m.id_prediction_i;
  assign bus_s.id_funct3_i     = bus_m.id_funct3_i;
  assign bus_s.id_pc_i         = bus_m.id_pc_i;
  assign bus_s.id_target_i     = bus_m.id_target_i;
  assign bus_s.ex_rs1_data_i   = bus_m.ex_rs1_data_i;
  assign bus_s.ex_rs2_data_i   = bus_m.ex_rs2_data_i;

  int checks   = 0;
  int failures = 0;

  // expected resolution: {taken, flush, redirect_pc}
  logic [33:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic taken, input logic flush, input logic [31:0] pc);
    exp_q.push_back({taken, flush, pc});
  endtask

  // apply one cycle of inputs, return just after the closing edge
  task automatic step(input logic stall, input logic br, input logic pred,
                      input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic [31:0] rs1,
                      input logic [31:0] rs2);
    bus_m.stall_i         = stall;
    bus_m.id_branch_i     = br;
    bus_m.id_prediction_i = pred;
    bus_m.id_funct3_i     = f3;
    bus_m.id_pc_i         = pc;
    bus_m.id_target_i     = tgt;
    bus_m.ex_rs1_data_i   = rs1;
    bus_m.ex_rs2_data_i   = rs2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] rs1, input logic [31:0] rs2);
    step(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, rs1, rs2);
  endtask

  task automatic chk_cnt(input string name, input int bc, input int mc);
    chk({name, "_branch_count"},     64'(bus_m.branch_count_o),     64'(bc));
    chk({name, "_mispredict_count"}, 64'(bus_m.mispredict_count_o), 64'(mc));
  endtask

  // monitor: every strobe must match the oldest queued expectation; with no
  // strobe all result outputs must be idle
  always @(negedge clk) begin
    chk("redirect_valid_eq_flush", 64'(bus_m.redirect_valid_o), 64'(bus_m.flush_o));
    if (bus_m.branch_taken_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual=taken:%0b flush:%0b pc:%0h required=no strobe",
                 bus_m.branch_taken_o, bus_m.flush_o, bus_m.redirect_pc_o);
      end else begin
        chk("resolve", 64'({bus_m.branch_taken_o, bus_m.flush_o, bus_m.redirect_pc_o}),
            64'(exp_q.pop_front()));
      end
    end else begin
      chk("idle_outputs", 64'({bus_m.branch_taken_o, bus_m.flush_o, bus_m.redirect_pc_o}), 64'(0));
    end
  end

  initial begin
    // reset held two cycles with a branch present in ID
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1, 3'b000, 32'h10, 32'h20, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 3'b000, 32'h10, 32'h20, 32'h0, 32'h0);
    chk_cnt("reset", 0, 0);
    rst = 1'b0;

    // BEQ predicted taken, taken
    step(1'b0, 1'b1, 1'b1, 3'b000, 32'h100, 32'h140, 32'h0, 32'h0);
    expect_res(1'b1, 1'b0, 32'h0);
    idle(32'd5, 32'd5);
    chk_cnt("beq", 1, 0);

    // BLT predicted taken, 3 < -1 signed is false
    step(1'b0, 1'b1, 1'b1, 3'b100, 32'h200, 32'h300, 32'h0, 32'h0);
    expect_res(1'b0, 1'b1, 32'h204);
    idle(32'd3, 32'hFFFF_FFFF);
    chk_cnt("blt", 2, 1);

    // BLTU predicted not taken, taken; next ID branch is squashed
    step(1'b0, 1'b1, 1'b0, 3'b110, 32'h300, 32'h80, 32'h0, 32'h0);
    expect_res(1'b1, 1'b1, 32'h80);
    step(1'b0, 1'b1, 1'b1, 3'b000, 32'h400, 32'h440, 32'd3, 32'hFFFF_FFFF);
    chk_cnt("bltu", 3, 2);
    idle(32'd0, 32'd0);
    chk_cnt("squashed", 3, 2);

    // back-to-back correct predictions: BNE not taken, BGE taken
    step(1'b0, 1'b1, 1'b0, 3'b001, 32'h500, 32'h540, 32'h0, 32'h0);
    expect_res(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 3'b101, 32'h600, 32'h640, 32'd7, 32'd7);
    expect_res(1'b1, 1'b0, 32'h0);
    idle(32'hFFFF_FFFE, 32'hFFFF_FFFB);
    chk_cnt("b2b", 5, 2);

    // funct3 010 resolves not taken and counts
    step(1'b0, 1'b1, 1'b1, 3'b010, 32'h700, 32'h800, 32'h0, 32'h0);
    expect_res(1'b0, 1'b1, 32'h704);
    idle(32'd9, 32'd9);
    chk_cnt("f3_010", 6, 3);

    // BGEU at top of PC space: fall-through wraps to 0
    step(1'b0, 1'b1, 1'b1, 3'b111, 32'hFFFF_FFFC, 32'h1000, 32'h0, 32'h0);
    expect_res(1'b0, 1'b1, 32'h0);
    idle(32'd0, 32'd1);
    chk_cnt("wrap", 7, 4);

    // stall two cycles, then release: one strobe after release
    step(1'b1, 1'b1, 1'b0, 3'b000, 32'h900, 32'h940, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 3'b000, 32'h900, 32'h940, 32'h0, 32'h0);
    chk_cnt("stalled", 7, 4);
    step(1'b0, 1'b1, 1'b0, 3'b000, 32'h900, 32'h940, 32'h0, 32'h0);
    expect_res(1'b0, 1'b0, 32'h0);
    idle(32'd1, 32'd2);
    chk_cnt("stall", 8, 4);

    // flush and stall together: flush wins, ID branch dropped
    step(1'b0, 1'b1, 1'b1, 3'b000, 32'hA00, 32'hA40, 32'h0, 32'h0);
    expect_res(1'b0, 1'b1, 32'hA04);
    step(1'b1, 1'b1, 1'b1, 3'b000, 32'hB00, 32'hB40, 32'd1, 32'd2);
    idle(32'd0, 32'd0);
    chk_cnt("flush_stall", 9, 5);

    // reset during resolution: strobe still seen this cycle, then lost
    step(1'b0, 1'b1, 1'b0, 3'b001, 32'hB00, 32'hB80, 32'h0, 32'h0);
    expect_res(1'b1, 1'b1, 32'hB80);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1, 3'b000, 32'hC00, 32'hC40, 32'd1, 32'd2);
    rst = 1'b0;
    chk_cnt("mid_reset", 0, 0);
    idle(32'd0, 32'd0);
    chk_cnt("after_reset", 0, 0);

    // five mispredictions: narrow counters saturate at 3
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 3'b000, 32'hD00 + 32'(i * 16), 32'hE00, 32'h0, 32'h0);
      expect_res(1'b0, 1'b1, 32'hD04 + 32'(i * 16));
      idle(32'd1, 32'd2);
    end
    chk_cnt("sat_wide", 5, 5);
    chk("sat_branch_count",     64'(bus_s.branch_count_o),     64'(3));
    chk("sat_mispredict_count", 64'(bus_s.mispredict_count_o), 64'(3));

    idle(32'd0, 32'd0);
    idle(32'd0, 32'd0);
    chk("pending_expectations", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
